dmem_arbiter: RTL and testbench

Shares the single port of the data-cache bram between two requesters:
- Port 0 is the CPU data_mov load/store path.
- Port 1 is the UART firmware-loader/debug path.

Each access is a single word, handled by a three-state sequencer with a per-port req/done handshake. Arbitration is round-robin. The loader can assert a lock to exclude the CPU. Out-of-range addresses are trapped without touching memory.

---
 rtl/dmem_arbiter_pkg.sv | 12 +
 rtl/dmem_arbiter_rr_pick2.sv | 13 +
 rtl/dmem_arbiter.sv | 138 +++++++++++++
 tb/tb_dmem_arbiter.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_arbiter_pkg.sv
// Shared constants for the data-memory arbiter: sequencer state encodings and
// requester port indices.
package dmem_arbiter_pkg;

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_ACCESS = 2'd1;
    localparam logic [1:0] S_RESP   = 2'd2;

    localparam logic P_CPU = 1'b0;
    localparam logic P_LDR = 1'b1;

endpackage

// File: rtl/dmem_arbiter_rr_pick2.sv
// Two-way round-robin picker: a lone eligible port wins outright, a tie goes
// to the port that was not granted last.
module rr_pick2 (
    input  logic [1:0] eligible,
    input  logic       last_gnt,
    output logic       valid,
    output logic       gnt
);

    assign valid = |eligible;
    assign gnt   = (&eligible) ? ~last_gnt : eligible[1];

endmodule

// File: rtl/dmem_arbiter.sv
// Single-port BRAM arbiter between the CPU data path (port 0) and the UART
// loader (port 1): one word per grant, IDLE -> ACCESS -> RESP.
module dmem_arbiter
    import dmem_arbiter_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DEPTH  = 1024,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0,
    input  logic              wr0,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [DATA_W-1:0] wdata0,
    output logic              done0,
    output logic [DATA_W-1:0] rdata0,
    input  logic              req1,
    input  logic              wr1,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata1,
    output logic              done1,
    output logic [DATA_W-1:0] rdata1,
    input  logic              lock1,
    output logic              err,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_write,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    logic [1:0]        r_state;
    logic              r_gnt;
    logic              r_last_gnt;
    logic              r_wr;
    logic              r_oor;
    logic              r_done0;
    logic              r_done1;
    logic              r_err;
    logic              r_mem_write;
    logic [ADDR_W-1:0] r_mem_addr;
    logic [DATA_W-1:0] r_mem_wdata;
    logic [DATA_W-1:0] r_hold0;
    logic [DATA_W-1:0] r_hold1;

    logic [1:0]        w_eligible;
    logic              w_valid;
    logic              w_gnt;
    logic              w_sel_wr;
    logic [ADDR_W-1:0] w_sel_addr;
    logic [DATA_W-1:0] w_sel_wdata;
    logic              w_sel_oor;
    logic [DATA_W-1:0] w_resp_data;
    logic              w_resp0;
    logic              w_resp1;

    // Lock only masks the CPU at arbitration time; a granted access always runs out.
    assign w_eligible = {req1, req0 & ~lock1};

    rr_pick2 u_pick (
        .eligible (w_eligible),
        .last_gnt (r_last_gnt),
        .valid    (w_valid),
        .gnt      (w_gnt)
    );

    assign w_sel_wr    = (w_gnt == P_LDR) ? wr1    : wr0;
    assign w_sel_addr  = (w_gnt == P_LDR) ? addr1  : addr0;
    assign w_sel_wdata = (w_gnt == P_LDR) ? wdata1 : wdata0;
    assign w_sel_oor   = (w_sel_addr >= ADDR_W'(DEPTH));

    // BRAM output is registered, so its data is only present during RESP.
    assign w_resp_data = (r_oor | r_wr) ? '0 : mem_rdata;
    assign w_resp0     = (r_state == S_RESP) && (r_gnt == P_CPU);
    assign w_resp1     = (r_state == S_RESP) && (r_gnt == P_LDR);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= S_IDLE;
            r_gnt       <= P_CPU;
            r_last_gnt  <= P_LDR;
            r_wr        <= 1'b0;
            r_oor       <= 1'b0;
            r_done0     <= 1'b0;
            r_done1     <= 1'b0;
            r_err       <= 1'b0;
            r_mem_write <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_hold0     <= '0;
            r_hold1     <= '0;
        end else begin
            r_done0     <= 1'b0;
            r_done1     <= 1'b0;
            r_err       <= 1'b0;
            r_mem_write <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_valid) begin
                        r_gnt       <= w_gnt;
                        r_wr        <= w_sel_wr;
                        r_oor       <= w_sel_oor;
                        r_mem_addr  <= w_sel_addr;
                        r_mem_wdata <= w_sel_wdata;
                        r_mem_write <= w_sel_wr & ~w_sel_oor;
                        r_state     <= S_ACCESS;
                    end
                end
                S_ACCESS: begin
                    r_done0 <= (r_gnt == P_CPU);
                    r_done1 <= (r_gnt == P_LDR);
                    r_err   <= r_oor;
                    r_state <= S_RESP;
                end
                S_RESP: begin
                    r_last_gnt <= r_gnt;
                    if (r_gnt == P_CPU) begin
                        r_hold0 <= w_resp_data;
                    end else begin
                        r_hold1 <= w_resp_data;
                    end
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign done0     = r_done0;
    assign done1     = r_done1;
    assign err       = r_err;
    assign rdata0    = w_resp0 ? w_resp_data : r_hold0;
    assign rdata1    = w_resp1 ? w_resp_data : r_hold1;
    assign mem_addr  = r_mem_addr;
    assign mem_write = r_mem_write;
    assign mem_wdata = r_mem_wdata;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Scoreboard bench for dmem_arbiter: requesters push expected responses, a
// negedge monitor pops and compares on every done / mem_write.
module tb_dmem_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        req0 = 1'b0, wr0 = 1'b0, req1 = 1'b0, wr1 = 1'b0, lock1 = 1'b0;
    logic [31:0] addr0 = '0, wdata0 = '0, addr1 = '0, wdata1 = '0;
    logic        done0, done1, err, mem_write;
    logic [31:0] rdata0, rdata1, mem_addr, mem_wdata;
    logic [31:0] mem_rdata;
    logic [31:0] mem [0:1023];

    int checks   = 0;
    int failures = 0;
    int n_done0  = 0;
    int n_done1  = 0;

    logic [31:0] q_rd0[$];
    logic [31:0] q_rd1[$];
    logic        q_err0[$];
    logic        q_err1[$];
    logic [63:0] q_w0[$];
    logic [63:0] q_w1[$];
    int          q_order[$];

    dmem_arbiter #(.ADDR_W(32), .DEPTH(1024), .DATA_W(32)) dut (
        .clk       (clk),
        .rst       (rst),
        .req0      (req0),
        .wr0       (wr0),
        .addr0     (addr0),
        .wdata0    (wdata0),
        .done0     (done0),
        .rdata0    (rdata0),
        .req1      (req1),
        .wr1       (wr1),
        .addr1     (addr1),
        .wdata1    (wdata1),
        .done1     (done1),
        .rdata1    (rdata1),
        .lock1     (lock1),
        .err       (err),
        .mem_addr  (mem_addr),
        .mem_write (mem_write),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata)
    );

    always #5 clk = ~clk;

    // Registered, read-first single-port BRAM.
    always @(posedge clk) begin
        if (mem_write) mem[mem_addr[9:0]] <= mem_wdata;
        mem_rdata <= mem[mem_addr[9:0]];
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    // Monitor: every done, err and mem_write must match a queued expectation.
    initial begin
        logic [63:0] w;
        forever begin
            @(negedge clk);
            if (done0 && done1) chk("done_overlap", 32'(done1), 32'd0);
            if (err && !done0 && !done1) chk("err_without_done", 32'(err), 32'd0);
            if (done0) begin
                n_done0++;
                if (q_rd0.size() == 0) begin
                    chk("unexpected_done0", 32'd1, 32'd0);
                end else begin
                    chk("rdata0", rdata0, q_rd0.pop_front());
                    chk("err_port0", 32'(err), 32'(q_err0.pop_front()));
                end
                if (q_order.size() > 0) chk("grant_order", 32'd0, 32'(q_order.pop_front()));
            end
            if (done1) begin
                n_done1++;
                if (q_rd1.size() == 0) begin
                    chk("unexpected_done1", 32'd1, 32'd0);
                end else begin
                    chk("rdata1", rdata1, q_rd1.pop_front());
                    chk("err_port1", 32'(err), 32'(q_err1.pop_front()));
                end
                if (q_order.size() > 0) chk("grant_order", 32'd1, 32'(q_order.pop_front()));
            end
            if (mem_write) begin
                w = {mem_addr, mem_wdata};
                if (q_w0.size() > 0 && q_w0[0] == w) begin
                    void'(q_w0.pop_front());
                    chk("mem_write_match", 32'd1, 32'd1);
                end else if (q_w1.size() > 0 && q_w1[0] == w) begin
                    void'(q_w1.pop_front());
                    chk("mem_write_match", 32'd1, 32'd1);
                end else begin
                    chk("mem_write_unexpected", mem_addr, 32'hFFFF_FFFF);
                end
            end
        end
    end

    task automatic do_req(input int p, input logic w, input logic [31:0] a,
                          input logic [31:0] d, input logic [31:0] erd, input logic eerr);
        int k;
        if (p == 0) begin
            q_rd0.push_back(erd);
            q_err0.push_back(eerr);
            if (w && !eerr) q_w0.push_back({a, d});
        end else begin
            q_rd1.push_back(erd);
            q_err1.push_back(eerr);
            if (w && !eerr) q_w1.push_back({a, d});
        end
        @(negedge clk);
        if (p == 0) begin
            req0 = 1'b1; wr0 = w; addr0 = a; wdata0 = d;
        end else begin
            req1 = 1'b1; wr1 = w; addr1 = a; wdata1 = d;
        end
        for (k = 0; k < 200; k++) begin
            @(negedge clk);
            if ((p == 0) ? done0 : done1) break;
        end
        if (k >= 200) begin
            checks++;
            failures++;
            $display("FAIL timeout_port%0d actual=no_done required=done", p);
        end
        if (p == 0) req0 = 1'b0;
        else        req1 = 1'b0;
    endtask

    initial begin
        int k;
        int n0;
        int n1;

        repeat (3) @(negedge clk);
        chk("rst_done0", 32'(done0), 32'd0);
        chk("rst_done1", 32'(done1), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        chk("rst_mem_write", 32'(mem_write), 32'd0);
        chk("rst_mem_addr", mem_addr, 32'd0);
        chk("rst_mem_wdata", mem_wdata, 32'd0);
        chk("rst_rdata0", rdata0, 32'd0);
        chk("rst_rdata1", rdata1, 32'd0);
        rst = 1'b1;

        // CPU write then read back, plus range boundary.
        do_req(0, 1'b1, 32'd5, 32'hDEADBEEF, 32'd0, 1'b0);
        do_req(0, 1'b0, 32'd5, 32'hDEADBEEF, 32'hDEADBEEF, 1'b0);
        do_req(0, 1'b0, 32'd1024, 32'd0, 32'd0, 1'b1);
        do_req(0, 1'b1, 32'd1024, 32'h0000_1234, 32'd0, 1'b1);
        do_req(0, 1'b1, 32'd1023, 32'h0000_55AA, 32'd0, 1'b0);
        do_req(0, 1'b0, 32'd1023, 32'd0, 32'h0000_55AA, 1'b0);
        do_req(1, 1'b0, 32'd5, 32'd0, 32'hDEADBEEF, 1'b0);

        // Loader lock holds off a waiting CPU request.
        @(negedge clk);
        lock1 = 1'b1;
        n0 = n_done0;
        fork
            do_req(0, 1'b0, 32'd5, 32'd0, 32'hDEADBEEF, 1'b0);
            begin
                do_req(1, 1'b1, 32'd40, 32'hA5A5_0001, 32'd0, 1'b0);
                do_req(1, 1'b0, 32'd40, 32'd0, 32'hA5A5_0001, 1'b0);
                chk("rdata0_hold", rdata0, 32'h0000_55AA);
                repeat (4) @(negedge clk);
                chk("locked_no_done0", 32'(n_done0), 32'(n0));
                lock1 = 1'b0;
                for (k = 1; k <= 10; k++) begin
                    @(negedge clk);
                    if (done0) break;
                end
                chk("unlock_latency_le3", 32'(k <= 3), 32'd1);
            end
        join

        // Lock raised during the CPU's RESP cycle.
        fork
            do_req(0, 1'b0, 32'd1023, 32'd0, 32'h0000_55AA, 1'b0);
            begin
                for (int j = 0; j < 20; j++) begin
                    @(negedge clk);
                    if (done0) break;
                end
                lock1 = 1'b1;
            end
        join
        fork
            do_req(0, 1'b0, 32'd5, 32'd0, 32'hDEADBEEF, 1'b0);
            begin
                n0 = n_done0;
                repeat (6) @(negedge clk);
                chk("blocked_after_lock", 32'(n_done0), 32'(n0));
                lock1 = 1'b0;
            end
        join

        // Reset during a loader write in ACCESS.
        q_w1.push_back({32'd7, 32'h0000_0077});
        @(negedge clk);
        req1 = 1'b1; wr1 = 1'b1; addr1 = 32'd7; wdata1 = 32'h0000_0077;
        for (k = 0; k < 10; k++) begin
            @(negedge clk);
            if (mem_write) break;
        end
        chk("abort_reached_access", 32'(k < 10), 32'd1);
        n1 = n_done1;
        #2 rst = 1'b0;
        #1;
        chk("abort_mem_write_low", 32'(mem_write), 32'd0);
        chk("abort_done1_low", 32'(done1), 32'd0);
        req1 = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        chk("abort_no_done1", 32'(n_done1), 32'(n1));

        // Simultaneous requests after reset alternate, CPU first.
        for (int i = 0; i < 4; i++) begin
            q_order.push_back(0);
            q_order.push_back(1);
        end
        fork
            for (int i = 0; i < 4; i++)
                do_req(0, 1'b1, 32'd16 + 32'(i), 32'h1000_0000 + 32'(i), 32'd0, 1'b0);
            for (int i = 0; i < 4; i++)
                do_req(1, 1'b1, 32'd32 + 32'(i), 32'h2000_0000 + 32'(i), 32'd0, 1'b0);
        join
        chk("order_consumed", 32'(q_order.size()), 32'd0);
        do_req(0, 1'b0, 32'd17, 32'd0, 32'h1000_0001, 1'b0);
        do_req(1, 1'b0, 32'd34, 32'd0, 32'h2000_0002, 1'b0);

        repeat (3) @(negedge clk);
        chk("queues_drained",
            32'(q_rd0.size() + q_rd1.size() + q_w0.size() + q_w1.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog");
    end

endmodule
